// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one quick_spi master among NUM_CLIENTS requesters.
// Issue-to-done latency = 2 + master response time; requests wait in req_i while a transaction is owned.
module spi_request_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_DATA_WIDTH = 4,
    parameter int STARTUP_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_CLIENTS-1:0]                req_i,
    input  logic [NUM_CLIENTS*NUM_DATA_WIDTH-1:0] num_data_i,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]     data_i,
    output logic [NUM_CLIENTS-1:0]                grant_o,
    output logic [NUM_CLIENTS-1:0]                done_o,
    output logic                                  error_o,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic                                  spi_request_o,
    output logic [NUM_DATA_WIDTH-1:0]             spi_num_data_o,
    output logic [DATA_WIDTH-1:0]                 spi_data_o,
    input  logic [DATA_WIDTH-1:0]                 spi_data_i,
    input  logic                                  spi_data_valid_i
);
    localparam int IDXW = $clog2(NUM_CLIENTS);
    localparam int CMAX = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_VALID,
        ST_RESPOND
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [IDXW-1:0]            last_q, last_d;
    logic [IDXW-1:0]            sel_q, sel_d;
    logic [NUM_CLIENTS-1:0]     grant_q, grant_d;
    logic [NUM_CLIENTS-1:0]     done_q, done_d;
    logic                       error_q, error_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       req_q, req_d;
    logic [NUM_DATA_WIDTH-1:0]  num_q, num_d;
    logic [DATA_WIDTH-1:0]      sdata_q, sdata_d;

    logic                       win_vld;
    logic [IDXW-1:0]            win_sel;
    logic [NUM_DATA_WIDTH-1:0]  win_num;
    logic [DATA_WIDTH-1:0]      win_data;

    // Two passes give the rotating search: indices above last_winner first, then wrap to 0..last_winner.
    always_comb begin
        win_vld  = 1'b0;
        win_sel  = '0;
        win_num  = '0;
        win_data = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!win_vld && req_i[k] && (IDXW'(k) > last_q)) begin
                win_vld  = 1'b1;
                win_sel  = IDXW'(k);
                win_num  = num_data_i[k*NUM_DATA_WIDTH +: NUM_DATA_WIDTH];
                win_data = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!win_vld && req_i[k] && (IDXW'(k) <= last_q)) begin
                win_vld  = 1'b1;
                win_sel  = IDXW'(k);
                win_num  = num_data_i[k*NUM_DATA_WIDTH +: NUM_DATA_WIDTH];
                win_data = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        done_d  = done_q;
        error_d = error_q;
        rdata_d = rdata_q;
        req_d   = 1'b0;
        num_d   = num_q;
        sdata_d = sdata_q;
        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (win_vld) begin
                    sel_d   = win_sel;
                    grant_d = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << win_sel;
                    num_d   = win_num;
                    sdata_d = win_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
                // cnt_q counts from the ISSUE cycle, so RESPOND lands TIMEOUT_CYCLES after issue.
                if (spi_data_valid_i) begin
                    rdata_d = spi_data_i;
                    done_d  = grant_q;
                    error_d = 1'b0;
                    state_d = ST_RESPOND;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    done_d  = grant_q;
                    error_d = 1'b1;
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                done_d  = '0;
                error_d = 1'b0;
                grant_d = '0;
                last_d  = sel_q;
                cnt_d   = '0;
                state_d = error_q ? ST_STARTUP : ST_IDLE;
            end
            default: begin
                state_d = ST_STARTUP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_STARTUP;
            cnt_q   <= '0;
            last_q  <= IDXW'(NUM_CLIENTS - 1);
            sel_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            error_q <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            num_q   <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            num_q   <= num_d;
            sdata_q <= sdata_d;
        end
    end

    assign grant_o        = grant_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign rdata_o        = rdata_q;
    assign spi_request_o  = req_q;
    assign spi_num_data_o = num_q;
    assign spi_data_o     = sdata_q;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Directed bench for spi_request_arbiter: vector table of single transactions plus
// hand sequences for contention, late drops, timeout and mid-transfer reset.
module tb_spi_request_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int NW = 4;
    localparam int SC = 16;
    localparam int TC = 1024;

    localparam logic [N*NW-1:0] NUMS  = {4'd9, 4'd8, 4'd7, 4'd6};
    localparam logic [N*NW-1:0] NUMS0 = {4'd0, 4'd8, 4'd7, 4'd6};
    localparam logic [N*DW-1:0] DATAS = {16'hD003, 16'hA5C3, 16'hB001, 16'hC000};

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [N-1:0]      req_i = '0;
    logic [N*NW-1:0]   num_data_i = NUMS;
    logic [N*DW-1:0]   data_i = DATAS;
    logic [N-1:0]      grant_o, done_o;
    logic              error_o;
    logic [DW-1:0]     rdata_o;
    logic              spi_request_o;
    logic [NW-1:0]     spi_num_data_o;
    logic [DW-1:0]     spi_data_o;
    logic [DW-1:0]     spi_data_i = '0;
    logic              spi_data_valid_i = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    spi_request_arbiter #(
        .NUM_CLIENTS(N), .DATA_WIDTH(DW), .NUM_DATA_WIDTH(NW),
        .STARTUP_CYCLES(SC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .num_data_i(num_data_i),
        .data_i(data_i), .grant_o(grant_o), .done_o(done_o), .error_o(error_o),
        .rdata_o(rdata_o), .spi_request_o(spi_request_o), .spi_num_data_o(spi_num_data_o),
        .spi_data_o(spi_data_o), .spi_data_i(spi_data_i), .spi_data_valid_i(spi_data_valid_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0]    req;
        logic [N*NW-1:0] nums;
        logic [DW-1:0]   rsp;
        logic [N-1:0]    eg;
        logic [NW-1:0]   en;
        logic [DW-1:0]   ed;
        int              lat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({grant_o, done_o, error_o, rdata_o, spi_request_o, spi_num_data_o, spi_data_o});
    endfunction

    // One transaction: wait for issue, check the issued values, answer after lat WAIT cycles.
    task automatic do_txn(input string nm, input logic [N-1:0] eg, input logic [NW-1:0] en,
                          input logic [DW-1:0] ed, input logic [DW-1:0] rsp,
                          input logic [N-1:0] drop, input int lat, output int waited);
        int nreq;
        waited = 0;
        while (!spi_request_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        chk({nm, "_req_seen"}, 64'(spi_request_o), 64'd1);
        if (!spi_request_o) return;
        chk({nm, "_grant"}, 64'(grant_o), 64'(eg));
        chk({nm, "_num"}, 64'(spi_num_data_o), 64'(en));
        chk({nm, "_data"}, 64'(spi_data_o), 64'(ed));
        nreq = 1;
        @(negedge clk_i);
        nreq += int'(spi_request_o);
        req_i = req_i & ~drop;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk_i);
            nreq += int'(spi_request_o);
        end
        spi_data_i       = rsp;
        spi_data_valid_i = 1'b1;
        @(negedge clk_i);
        spi_data_valid_i = 1'b0;
        spi_data_i       = '0;
        chk({nm, "_done"}, 64'(done_o), 64'(eg));
        chk({nm, "_rdata"}, 64'(rdata_o), 64'(rsp));
        chk({nm, "_error"}, 64'(error_o), 64'd0);
        chk({nm, "_grant_held"}, 64'(grant_o), 64'(eg));
        chk({nm, "_one_request"}, 64'(nreq), 64'd1);
        @(negedge clk_i);
        chk({nm, "_done_cleared"}, 64'(done_o), 64'd0);
        chk({nm, "_grant_cleared"}, 64'(grant_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, first_wait, t, ev;

        // Round-robin pointer traced by hand: starts at 3, so client 0 is searched first.
        tbl[0] = '{4'b0100, NUMS,  16'h1234, 4'b0100, 4'd8, 16'hA5C3, 3};
        tbl[1] = '{4'b1111, NUMS,  16'hBEEF, 4'b1000, 4'd9, 16'hD003, 1};
        tbl[2] = '{4'b1111, NUMS,  16'h0001, 4'b0001, 4'd6, 16'hC000, 5};
        tbl[3] = '{4'b0101, NUMS,  16'hFFFF, 4'b0100, 4'd8, 16'hA5C3, 2};
        tbl[4] = '{4'b0011, NUMS,  16'h5A5A, 4'b0001, 4'd6, 16'hC000, 1};
        tbl[5] = '{4'b1000, NUMS0, 16'h8001, 4'b1000, 4'd0, 16'hD003, 4};
        tbl[6] = '{4'b0010, NUMS,  16'h7E57, 4'b0010, 4'd7, 16'hB001, 2};

        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        first_wait = 0;
        for (int i = 0; i < 7; i++) begin
            req_i      = tbl[i].req;
            num_data_i = tbl[i].nums;
            do_txn($sformatf("vec%0d", i), tbl[i].eg, tbl[i].en, tbl[i].ed, tbl[i].rsp,
                   4'b0000, tbl[i].lat, w);
            if (i == 0) first_wait = w;
            req_i      = '0;
            num_data_i = NUMS;
        end
        // Request raised in cycle 1 after release; issue is observed in cycle (1 + first_wait + 1).
        chk("startup_gap", 64'((first_wait + 2) >= (SC + 2)), 64'd1);

        // Contention from reset: all four request continuously.
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 4'b1111;
        #1;
        chk("reset_again_outputs", all_outs(), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        do_txn("rr0", 4'b0001, 4'd6, 16'hC000, 16'h1000, 4'b0000, 2, w);
        do_txn("rr1", 4'b0010, 4'd7, 16'hB001, 16'h1001, 4'b0000, 1, w);
        do_txn("rr2", 4'b0100, 4'd8, 16'hA5C3, 16'h1002, 4'b0000, 3, w);
        do_txn("rr3", 4'b1000, 4'd9, 16'hD003, 16'h1003, 4'b0000, 1, w);
        do_txn("rr4", 4'b0001, 4'd6, 16'hC000, 16'h1004, 4'b0000, 2, w);
        req_i = '0;

        // Late drop: client 1 releases req one cycle after its grant yet still completes.
        req_i = 4'b0110;
        do_txn("late_drop", 4'b0010, 4'd7, 16'hB001, 16'h2222, 4'b0010, 2, w);
        do_txn("after_drop", 4'b0100, 4'd8, 16'hA5C3, 16'h3333, 4'b0000, 1, w);
        req_i = '0;

        // Client 1 gives up before winning; a stray valid in IDLE must be ignored.
        req_i = 4'b0011;
        do_txn("early_drop", 4'b0001, 4'd6, 16'hC000, 16'h4444, 4'b0010, 2, w);
        req_i = '0;
        ev = 0;
        for (int i = 0; i < 40; i++) begin
            spi_data_valid_i = (i == 5);
            spi_data_i       = 16'h9999;
            @(negedge clk_i);
            ev += int'(spi_request_o) + int'(grant_o != 0) + int'(done_o != 0) + int'(error_o);
        end
        spi_data_valid_i = 1'b0;
        spi_data_i       = '0;
        chk("quiet_no_activity", 64'(ev), 64'd0);

        // Timeout: the master never answers.
        req_i = 4'b0001;
        w = 0;
        while (!spi_request_o && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        chk("to_req_seen", 64'(spi_request_o), 64'd1);
        t = 0;
        while (done_o == '0 && t < TC + 100) begin
            @(negedge clk_i);
            t++;
        end
        chk("to_latency", 64'(t), 64'(TC));
        chk("to_done", 64'(done_o), 64'b0001);
        chk("to_error", 64'(error_o), 64'd1);
        chk("to_rdata", 64'(rdata_o), 64'd0);
        do_txn("restart", 4'b0001, 4'd6, 16'hC000, 16'h4321, 4'b0000, 2, w);
        chk("restart_gap", 64'(w >= SC + 2), 64'd1);
        req_i = '0;

        // Reset while waiting for valid: everything clears at once, no done afterwards.
        req_i = 4'b0100;
        w = 0;
        while (!spi_request_o && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        chk("mid_req_seen", 64'(spi_request_o), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("mid_reset_outputs", all_outs(), 64'd0);
        req_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        ev = 0;
        for (int i = 0; i < 40; i++) begin
            spi_data_valid_i = (i == 1) || (i == 20);
            spi_data_i       = 16'h7777;
            @(negedge clk_i);
            ev += int'(done_o != 0) + int'(spi_request_o);
        end
        spi_data_valid_i = 1'b0;
        chk("mid_reset_no_done", 64'(ev), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_request_arbiter.md
SPI_REQUEST_ARBITER -- requirements
Module: spi_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4: number of requesters sharing one quick_spi master; valid values are 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of the quick_spi data bus (MAX_DATA_LENGTH*NUM_DEVICES).
REQ-003 SHALL have parameter NUM_DATA_WIDTH, default 4: width of a transfer-length field.
REQ-004 SHALL have parameter STARTUP_CYCLES, default 16: wait after reset or timeout before the first issue, covering the master's return to idle.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum wait for spi_data_valid_i after an issue.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port req_i, input, NUM_CLIENTS bits: per-client level request, held until that client's done_o.
REQ-009 SHALL have port num_data_i, input, NUM_CLIENTS*NUM_DATA_WIDTH bits: per-client transfer length; client k uses slice k.
REQ-010 SHALL have port data_i, input, NUM_CLIENTS*DATA_WIDTH bits: per-client write data.
REQ-011 SHALL have port grant_o, output, NUM_CLIENTS bits: one-hot owner of the current transaction.
REQ-012 SHALL have port done_o, output, NUM_CLIENTS bits: one-cycle completion pulse to the owner.
REQ-013 SHALL have port error_o, output, 1 bit: qualifies done_o; high means timeout.
REQ-014 SHALL have port rdata_o, output, DATA_WIDTH bits: read data, valid while any done_o bit is high.
REQ-015 SHALL have port spi_request_o, output, 1 bit: to quick_spi request_i.
REQ-016 SHALL have port spi_num_data_o, output, NUM_DATA_WIDTH bits: to quick_spi num_data_i.
REQ-017 SHALL have port spi_data_o, output, DATA_WIDTH bits: to quick_spi data_i.
REQ-018 SHALL have port spi_data_i, input, DATA_WIDTH bits: from quick_spi data_o.
REQ-019 SHALL have port spi_data_valid_i, input, 1 bit: from quick_spi data_valid_o.

Function
REQ-020 SHALL implement the states STARTUP, IDLE, ISSUE, WAIT_VALID and RESPOND.
REQ-021 SHALL run STARTUP by counting STARTUP_CYCLES clocks and then entering IDLE; no grant is issued in STARTUP.
REQ-022 SHALL, in IDLE with any req_i bit set, select a winner round-robin and register the winner's grant_o, spi_num_data_o and spi_data_o, then enter ISSUE on the next clock.
REQ-023 SHALL perform the round-robin search starting at index (last_winner+1) mod NUM_CLIENTS; last_winner resets to NUM_CLIENTS-1, so client 0 has first priority.
REQ-024 SHALL, in ISSUE, hold spi_request_o high for exactly one cycle and then enter WAIT_VALID; spi_request_o is low in every other state.
REQ-025 SHALL keep spi_num_data_o, spi_data_o and grant_o stable from ISSUE through RESPOND.
REQ-026 SHALL, in WAIT_VALID, capture spi_data_i into rdata_o on the cycle spi_data_valid_i is high, then enter RESPOND.
REQ-027 SHALL, in RESPOND, assert done_o equal to grant_o for one cycle, update last_winner, clear grant_o, and return to IDLE.
REQ-028 SHALL make the earliest next issue the cycle after RESPOND, so spi_request_o is never high while quick_spi is presenting data_valid_o.
REQ-029 SHALL, in WAIT_VALID, abandon the transfer once TIMEOUT_CYCLES clocks pass without spi_data_valid_i: enter RESPOND with error_o=1 and rdata_o=0, then enter STARTUP instead of IDLE.
REQ-030 SHALL ignore spi_data_valid_i outside WAIT_VALID.
REQ-031 SHALL ignore req_i changes after a grant: a client dropping req_i mid-transaction still completes and still receives done_o.
REQ-032 SHALL ignore a req_i bit dropped before it wins; that client gets no grant and no done_o.
REQ-033 SHALL pass a transfer length of 0 through unchanged, with no special handling.
REQ-034 SHALL keep grant_o at most one-hot and done_o at most one-hot at all times.
REQ-035 SHALL hold error_o low except during a timeout RESPOND cycle.

Reset
REQ-036 SHALL, on rst_i high at any time including mid-transaction, asynchronously force state=STARTUP, the startup counter to 0, grant_o=0, done_o=0, error_o=0, rdata_o=0, spi_request_o=0, spi_num_data_o=0, spi_data_o=0, and last_winner=NUM_CLIENTS-1.
REQ-037 SHALL, after rst_i falls, issue no spi_request_o until STARTUP_CYCLES have elapsed.

Verification
REQ-038 SHALL cover single client: client 2 requests with num_data=8 and data=0xA5C3; spi_request_o pulses once with those values; the model returns 0x1234 -> done_o=4'b0100, rdata_o=0x1234, error_o=0.
REQ-039 SHALL cover contention: req_i=4'b1111 held from reset -> grants in the order 0,1,2,3,0, with exactly one spi_request_o per grant.
REQ-040 SHALL cover a request during STARTUP: req_i set on cycle 1 after reset -> first spi_request_o no earlier than STARTUP_CYCLES+2 cycles after reset release.
REQ-041 SHALL cover timeout: the model never asserts valid -> done_o pulses exactly TIMEOUT_CYCLES cycles after ISSUE with error_o=1 and rdata_o=0, then STARTUP repeats.
REQ-042 SHALL cover reset mid-transfer: rst_i asserted in WAIT_VALID -> all outputs are 0 in the same cycle, and no done_o occurs for that transaction.
REQ-043 SHALL cover a late drop: a client drops req_i one cycle after its grant -> done_o still pulses for that client, and the next winner follows the round-robin order.
